// File: rtl/fnd_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : fnd_capture_if
// Description : Bundle of the scanned seven-segment bus and the decoded frame
//               outputs of the FND capture block.
// Revision    : 1.0 - initial release
// ============================================================================
interface fnd_capture_if;
    logic [7:0] seg_in;    // dp,g,f,e,d,c,b,a (active-high)
    logic [1:0] dig_sel;   // 01 = units strobe, 10 = tens strobe
    logic [3:0] bcd0;      // units digit of the last good frame
    logic [3:0] bcd1;      // tens digit of the last good frame
    logic [6:0] value;     // bcd1*10 + bcd0
    logic       valid;     // one-cycle new-frame pulse
    logic       err;       // one-cycle illegal-pattern / timeout pulse

    // Display driver side: drives the scan, observes the decoded frame
    modport master (
        output seg_in, dig_sel,
        input  bcd0, bcd1, value, valid, err
    );

    // Capture block side
    modport slave (
        input  seg_in, dig_sel,
        output bcd0, bcd1, value, valid, err
    );
endinterface
`default_nettype wire

// File: rtl/fnd_capture.sv
`default_nettype none
// ============================================================================
// Module      : fnd_capture
// Description : Two-digit seven-segment readback. Filters each scanned digit
//               for stability, decodes gfedcba back to BCD and assembles a
//               tens/units frame plus its binary value.
// Revision    : 1.0 - initial release
// ============================================================================
module fnd_capture #(
    parameter int STABLE  = 4,    // identical samples needed, 1..15
    parameter int TIMEOUT = 64    // cycles allowed per digit wait, >= 2
) (
    input  wire logic    clk,
    input  wire logic    rst,
    fnd_capture_if.slave bus
);

    localparam int             TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [3:0]     CNT_LAST   = 4'(STABLE - 1);
    localparam logic [TW-1:0]  TMO_LAST   = TW'(TIMEOUT - 1);
    localparam bit             ONE_SAMPLE = (STABLE == 1);

    typedef enum logic [1:0] {
        S_D0  = 2'd0,
        S_D1  = 2'd1,
        S_OUT = 2'd2
    } state_t;

    state_t        state;
    logic [6:0]    last;
    logic [3:0]    cnt;
    logic [TW-1:0] tmo;
    logic [3:0]    d0;

    logic [6:0]    pat;
    logic [3:0]    dec;
    logic          legal;
    logic          strobe_ok;
    logic          same;
    logic          accept;
    logic          tmo_hit;
    logic [6:0]    dec_x10;
    logic          dp_unused;

    // The decimal point carries no digit information
    assign dp_unused = bus.seg_in[7];
    assign pat       = bus.seg_in[6:0];

    // Segment pattern back to BCD; anything outside the ten glyphs is illegal
    always_comb begin
        legal = 1'b1;
        dec   = 4'd0;
        case (pat)
            7'h3F:   dec = 4'd0;
            7'h06:   dec = 4'd1;
            7'h5B:   dec = 4'd2;
            7'h4F:   dec = 4'd3;
            7'h66:   dec = 4'd4;
            7'h6D:   dec = 4'd5;
            7'h7D:   dec = 4'd6;
            7'h07:   dec = 4'd7;
            7'h7F:   dec = 4'd8;
            7'h6F:   dec = 4'd9;
            default: legal = 1'b0;
        endcase
    end

    // Only the strobe matching the digit being waited for feeds the filter
    assign strobe_ok = ((state == S_D0) && (bus.dig_sel == 2'b01)) ||
                       ((state == S_D1) && (bus.dig_sel == 2'b10));
    assign same      = (cnt != 4'd0) && (pat == last);
    // Accept when this sample completes the run of STABLE identical samples
    assign accept    = strobe_ok && (cnt == CNT_LAST) && (ONE_SAMPLE || same);
    assign tmo_hit   = (tmo == TMO_LAST);
    // decode*10 as (x<<3)+(x<<1)
    assign dec_x10   = ({3'b000, dec} << 3) + ({3'b000, dec} << 1);

    // Capture FSM with filter, timeout and registered frame/pulse outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_D0;
            last      <= 7'd0;
            cnt       <= 4'd0;
            tmo       <= '0;
            d0        <= 4'd0;
            bus.bcd0  <= 4'd0;
            bus.bcd1  <= 4'd0;
            bus.value <= 7'd0;
            bus.valid <= 1'b0;
            bus.err   <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            bus.err   <= 1'b0;
            case (state)
                S_D0, S_D1: begin
                    if (accept) begin
                        // Acceptance wins over a coincident timeout
                        cnt <= 4'd0;
                        tmo <= '0;
                        if (!legal) begin
                            bus.err <= 1'b1;
                            state   <= S_D0;
                        end else if (state == S_D0) begin
                            d0    <= dec;
                            state <= S_D1;
                        end else begin
                            bus.bcd1  <= dec;
                            bus.bcd0  <= d0;
                            bus.value <= dec_x10 + {3'b000, d0};
                            bus.valid <= 1'b1;
                            state     <= S_OUT;
                        end
                    end else if (tmo_hit) begin
                        bus.err <= 1'b1;
                        state   <= S_D0;
                        cnt     <= 4'd0;
                        tmo     <= '0;
                    end else begin
                        tmo <= tmo + 1'b1;
                        if (strobe_ok) begin
                            if (same) begin
                                cnt <= cnt + 4'd1;
                            end else begin
                                last <= pat;
                                cnt  <= 4'd1;
                            end
                        end else begin
                            cnt <= 4'd0;
                        end
                    end
                end
                S_OUT: begin
                    state <= S_D0;
                    cnt   <= 4'd0;
                    tmo   <= '0;
                end
                default: begin
                    state <= S_D0;
                    cnt   <= 4'd0;
                    tmo   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fnd_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_fnd_capture
// Description : Directed self-checking bench for fnd_capture with a run-length
//               reference model compared against the DUT every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fnd_capture;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fnd_capture_if bus ();

    fnd_capture #(
        .STABLE (STABLE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int valid_seen = 0;
    int err_seen   = 0;

    logic [6:0] seg_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model: phase 0 = waiting for units, 1 = tens, 2 = frame out
    typedef struct {
        int         phase;
        logic [6:0] run_pat;
        int         run_len;
        int         waited;
        int         units;
        int         bcd0;
        int         bcd1;
        int         value;
        bit         valid;
        bit         err;
    } mstate_t;

    mstate_t m;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int seg_digit(input logic [6:0] p);
        int d;
        d = -1;
        for (int i = 0; i < 10; i++)
            if (seg_tbl[i] == p) d = i;
        return d;
    endfunction

    function automatic mstate_t model_reset();
        mstate_t r;
        r.phase = 0; r.run_pat = 7'd0; r.run_len = 0; r.waited = 0; r.units = 0;
        r.bcd0 = 0; r.bcd1 = 0; r.value = 0; r.valid = 1'b0; r.err = 1'b0;
        return r;
    endfunction

    // A digit is taken once the trailing run of identical strobed samples in
    // the current phase reaches STABLE; a phase lasting TIMEOUT cycles errors.
    function automatic mstate_t model_next(input mstate_t c, input logic [1:0] sel,
                                           input logic [7:0] seg);
        mstate_t    n;
        logic [6:0] p;
        int         d;
        bit         active;
        n = c;
        p = seg[6:0];
        n.valid = 1'b0;
        n.err   = 1'b0;
        if (c.phase == 2) begin
            n.phase = 0; n.run_len = 0; n.waited = 0;
            return n;
        end
        active = (c.phase == 0) ? (sel == 2'b01) : (sel == 2'b10);
        if (active) begin
            if (n.run_len > 0 && p == n.run_pat) n.run_len++;
            else begin n.run_pat = p; n.run_len = 1; end
        end else begin
            n.run_len = 0;
        end
        if (n.run_len >= STABLE) begin
            d = seg_digit(p);
            n.run_len = 0;
            n.waited  = 0;
            if (d < 0) begin
                n.err = 1'b1; n.phase = 0;
            end else if (c.phase == 0) begin
                n.units = d; n.phase = 1;
            end else begin
                n.bcd1 = d; n.bcd0 = c.units; n.value = 10 * d + c.units;
                n.valid = 1'b1; n.phase = 2;
            end
        end else begin
            n.waited++;
            if (n.waited >= TIMEOUT) begin
                n.err = 1'b1; n.phase = 0; n.run_len = 0; n.waited = 0;
            end
        end
        return n;
    endfunction

    // Advance the model on the same edges the DUT samples
    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_next(m, bus.dig_sel, bus.seg_in);
    end

    // Compare DUT against the model on every falling edge out of reset
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", int'(bus.valid), int'(m.valid));
            chk("err",   int'(bus.err),   int'(m.err));
            chk("bcd0",  int'(bus.bcd0),  m.bcd0);
            chk("bcd1",  int'(bus.bcd1),  m.bcd1);
            chk("value", int'(bus.value), m.value);
            if (bus.valid) valid_seen++;
            if (bus.err)   err_seen++;
        end
    end

    // Present one sample per rising edge; returns on the falling edge after it
    task automatic drive(input logic [1:0] sel, input logic [7:0] seg, input int n);
        repeat (n) begin
            bus.dig_sel = sel;
            bus.seg_in  = seg;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        drive(2'b00, 8'h00, n);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_value", int'(bus.value), 0);
        chk("rst_async_bcd0",  int'(bus.bcd0),  0);
        chk("rst_async_bcd1",  int'(bus.bcd1),  0);
        chk("rst_async_valid", int'(bus.valid), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic frame_check(input string name, input int vd, input int ed,
                               input int val, input int v0, input int e0);
        chk({name, "_valid_cnt"}, valid_seen - v0, vd);
        chk({name, "_err_cnt"},   err_seen - e0,   ed);
        chk({name, "_value"},     int'(bus.value), val);
        chk({name, "_model"},     m.value,         val);
    endtask

    // Bound the run in case anything stalls
    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Directed scenarios
    initial begin
        int v0, e0;
        bus.seg_in  = 8'h00;
        bus.dig_sel = 2'b00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_valid", int'(bus.valid), 0);
        chk("reset_err",   int'(bus.err),   0);
        chk("reset_value", int'(bus.value), 0);
        rst = 1'b0;

        // Clean frame 45: valid right after the 8th edge, gone after the 9th
        v0 = valid_seen; e0 = err_seen;
        drive(2'b01, 8'h6D, 4);
        drive(2'b10, 8'h66, 4);
        chk("clean_valid_hi", int'(bus.valid), 1);
        chk("clean_bcd1", int'(bus.bcd1), 4);
        chk("clean_bcd0", int'(bus.bcd0), 5);
        idle(1);
        chk("clean_valid_lo", int'(bus.valid), 0);
        idle(2);
        frame_check("clean", 1, 0, 45, v0, e0);

        // Illegal units pattern: err, no frame, old frame holds
        v0 = valid_seen; e0 = err_seen;
        drive(2'b01, 8'h49, 4);
        chk("illegal_err_hi", int'(bus.err), 1);
        idle(2);
        frame_check("illegal", 0, 1, 45, v0, e0);

        // Following clean 00 frame
        v0 = valid_seen; e0 = err_seen;
        drive(2'b01, 8'h3F, 4);
        drive(2'b10, 8'h3F, 4);
        idle(2);
        frame_check("zero", 1, 0, 0, v0, e0);

        // Glitch in the units run restarts the filter
        v0 = valid_seen; e0 = err_seen;
        drive(2'b01, 8'h6D, 3);
        drive(2'b01, 8'h7D, 1);
        drive(2'b01, 8'h6D, 4);
        drive(2'b10, 8'h6F, 4);
        idle(2);
        frame_check("glitch", 1, 0, 95, v0, e0);

        // dp toggling must not break the run
        v0 = valid_seen; e0 = err_seen;
        drive(2'b01, 8'hBF, 1);
        drive(2'b01, 8'h3F, 1);
        drive(2'b01, 8'hBF, 1);
        drive(2'b01, 8'h3F, 1);
        drive(2'b10, 8'hEF, 4);
        idle(2);
        frame_check("dp", 1, 0, 90, v0, e0);

        // Maximum value
        v0 = valid_seen; e0 = err_seen;
        drive(2'b01, 8'h6F, 4);
        drive(2'b10, 8'h6F, 4);
        idle(2);
        frame_check("max", 1, 0, 99, v0, e0);
        chk("max_bcd1", int'(bus.bcd1), 9);
        chk("max_bcd0", int'(bus.bcd0), 9);

        // Illegal tens pattern drops the partial frame
        v0 = valid_seen; e0 = err_seen;
        drive(2'b01, 8'h06, 4);
        drive(2'b10, 8'h00, 4);
        idle(2);
        frame_check("illegal_tens", 0, 1, 99, v0, e0);

        // Reset mid-frame discards the captured units digit
        drive(2'b01, 8'h6D, 4);
        do_reset();
        v0 = valid_seen; e0 = err_seen;
        drive(2'b10, 8'h66, 4);
        idle(2);
        frame_check("rst_mid", 0, 0, 0, v0, e0);
        chk("rst_mid_bcd0", int'(bus.bcd0), 0);
        v0 = valid_seen; e0 = err_seen;
        drive(2'b01, 8'h06, 4);
        drive(2'b10, 8'h5B, 4);
        idle(2);
        frame_check("after_rst", 1, 0, 21, v0, e0);

        // Acceptance on the timeout edge wins
        do_reset();
        v0 = valid_seen; e0 = err_seen;
        idle(60);
        drive(2'b01, 8'h6D, 4);
        drive(2'b10, 8'h07, 4);
        idle(2);
        frame_check("accept_vs_tmo", 1, 0, 75, v0, e0);

        // Illegal acceptance on the timeout edge gives a single err
        do_reset();
        v0 = valid_seen; e0 = err_seen;
        idle(60);
        drive(2'b01, 8'h49, 4);
        idle(2);
        frame_check("illegal_vs_tmo", 0, 1, 0, v0, e0);

        // Idle timeout: err after edge 64 and edge 128
        do_reset();
        v0 = valid_seen; e0 = err_seen;
        idle(63);
        chk("tmo_edge63_err", int'(bus.err), 0);
        idle(1);
        chk("tmo_edge64_err", int'(bus.err), 1);
        idle(1);
        chk("tmo_edge65_err", int'(bus.err), 0);
        idle(63);
        chk("tmo_edge128_err", int'(bus.err), 1);
        idle(2);
        frame_check("tmo_idle", 0, 2, 0, v0, e0);

        // Mid-frame timeout: err 64 cycles after units accepted
        do_reset();
        v0 = valid_seen; e0 = err_seen;
        drive(2'b01, 8'h6D, 4);
        idle(63);
        chk("tmo_mid_pre", int'(bus.err), 0);
        idle(1);
        chk("tmo_mid_err", int'(bus.err), 1);
        drive(2'b01, 8'h06, 4);
        drive(2'b10, 8'h5B, 4);
        idle(2);
        frame_check("tmo_mid", 1, 1, 21, v0, e0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fnd_capture.md
# fnd_capture

Two-digit seven-segment (FND) capture block: the receiving end of the BCD-to-FND display path. It samples the scanned segment bus, filters each digit pattern for stability, decodes the active-high gfedcba pattern back to BCD, and assembles a tens/units frame with a binary value. It is used as an on-chip display readback monitor and as the checker end of display-path benches.

## Interface
Parameters:
- STABLE, 4: consecutive identical samples needed to accept a digit; legal range 1..15.
- TIMEOUT, 64: cycles allowed in a digit-wait state before an error; must be at least 2.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  asynchronous reset, active-high.
- seg_in  input  8  segment bus. Bit 7 is dp and is ignored. Bits 6:0 are g,f,e,d,c,b,a, active-high.
- dig_sel  input  2  one-hot digit strobe. 01 selects units (digit0), 10 selects tens (digit1); 00 and 11 mean no digit.
- bcd0  output  4  units digit of the last valid frame.
- bcd1  output  4  tens digit of the last valid frame.
- value  output  7  bcd1*10+bcd0, range 0..99.
- valid  output  1  one-cycle pulse marking a new frame.
- err  output  1  one-cycle pulse on an illegal pattern or a timeout.

## Operation
- Legal patterns on seg_in[6:0]: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Every other value, including 00, is illegal.
- Internal registers:
  - last: the previous 7-bit pattern.
  - cnt: stability count, 4 bits.
  - tmo: timeout count, width clog2(TIMEOUT).
  - d0: the captured units digit.
- Stability filter, applied in S_D0 and S_D1:
  - The strobe for the current state must be active: 01 in S_D0, 10 in S_D1.
  - If the strobe is active and either cnt==0 or seg_in[6:0]!=last: last<=seg_in[6:0], cnt<=1.
  - If the strobe is active and seg_in[6:0]==last: cnt<=cnt+1.
  - On any other dig_sel value: cnt<=0.
- Acceptance happens on the edge where the STABLE-th consecutive identical sample is present, i.e. cnt==STABLE-1 and the pattern matches (with STABLE=1, the first sample is accepted).
- FSM states:
  - S_D0: on accepting a legal pattern, d0<=decode, cnt<=0, tmo<=0, go to S_D1. On accepting an illegal pattern, err pulses, cnt<=0, tmo<=0, and the FSM stays in S_D0.
  - S_D1: on accepting a legal pattern, bcd1<=decode, bcd0<=d0, value<=decode*10+d0, go to S_OUT. On accepting an illegal pattern, err pulses, d0 is discarded, and the FSM goes to S_D0.
  - S_OUT: valid=1 for this single cycle and inputs are ignored; next state is S_D0 with cnt and tmo cleared.
- Timeout:
  - tmo increments every cycle in S_D0 and S_D1, and clears on every state change or acceptance.
  - On the edge with tmo==TIMEOUT-1 and no acceptance: err pulses, state<=S_D0, cnt<=0, tmo<=0.
- Priority:
  - Acceptance beats timeout on the same edge.
  - An illegal acceptance that coincides with a timeout gives one err pulse, not two.
- bcd0, bcd1 and value change only on entry to S_OUT; they hold the last good frame otherwise.

## Timing
- Reset values: state=S_D0, bcd0=0, bcd1=0, value=0, valid=0, err=0, last=0, cnt=0, tmo=0, d0=0. Reset applies immediately, and an assertion mid-frame discards any partial capture.
- All outputs are registered; valid is high exactly while state==S_OUT.
- Frame latency with a clean scan: digit0 is accepted on edge STABLE and digit1 on edge 2*STABLE. Outputs update and valid rises after edge 2*STABLE, and valid falls after edge 2*STABLE+1.
- err is a registered one-cycle pulse, high in the cycle after the triggering edge.
- The minimum frame period is 2*STABLE+1 cycles.

## Test plan
- Reset mid-frame: accept digit0=5, assert rst for 1 cycle, then drive dig_sel=10 with 66 for 4 cycles -> no valid; the FSM is still in S_D0 and all outputs are 0.
- Clean frame (STABLE=4):
  - Stimulus: dig_sel=01 with seg_in=6D for 4 cycles, then dig_sel=10 with seg_in=66 for 4 cycles.
  - Response: valid is high for 1 cycle after the 8th edge, with bcd1=4, bcd0=5, value=45. The outputs hold afterwards.
- Glitch filter: digit0 driven as 6D,6D,6D,7D,6D,6D,6D,6D, then tens=6F x4 -> one frame with value=95; the 7D sample is never accepted.
- Illegal pattern: dig_sel=01 with seg_in=49 for 4 cycles -> err pulse after the 4th edge, no valid, the FSM stays in S_D0. A following clean frame with 3F/3F then gives value=0.
- Timeout:
  - Idle case: dig_sel=00 from reset -> err after edge 64 and again after edge 128, with no valid.
  - Mid-frame case: accept digit0, then idle -> err 64 cycles later, and the next frame ignores the stale d0.
- dp bit and maximum value: digit0 alternating BF/3F, then digit1 EF x4 -> the dp bit does not reset the filter; the frame is value=90. A second frame of 6F/6F gives value=99.
